// File: rtl/dw_result_drain.sv
// Result drain behind the depthwise systolic array. It drops warm-up beats,
// requantizes each lane to DATA_WIDTH and queues the packed columns in a small FIFO.
module dw_result_drain #(
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int NUM_KCELLS     = 3,
    parameter int STRIP_COLS     = 114,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 res_valid,
    input  logic [NUM_KCELLS*OUT_DATA_WIDTH-1:0] result,
    input  logic signed [31:0]                   bias,
    input  logic [4:0]                           shift,
    input  logic                                 relu_en,
    output logic                                 in_ready,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_KCELLS*DATA_WIDTH-1:0]     out_data,
    output logic                                 strip_done,
    output logic                                 overflow
);

    localparam int CW = (STRIP_COLS > 1) ? $clog2(STRIP_COLS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int AW = 34;
    localparam int OW = OUT_DATA_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int LW = NUM_KCELLS * DATA_WIDTH;

    localparam logic [CW-1:0]        LAST_COL  = CW'(STRIP_COLS - 1);
    localparam logic [CW-1:0]        WARM_COLS = CW'(NUM_KCELLS - 1);
    localparam logic [PW:0]          DEPTH     = (PW + 1)'(FIFO_DEPTH);
    localparam logic signed [AW-1:0] ONE       = AW'(1);
    localparam logic signed [AW-1:0] U_MAX     = AW'((1 << DW) - 1);
    localparam logic signed [AW-1:0] S_MAX     = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] S_MIN     = ~S_MAX;

    // Column tracking
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [CW-1:0] eff_col;
    logic          strip_done_q, strip_done_d;
    logic          overflow_q, overflow_d;
    logic          kept;

    // S1 stage
    logic          s1_valid_q, s1_valid_d;
    logic [LW-1:0] s1_data_q, s1_data_d;

    // FIFO state
    logic [LW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW:0]   occ;
    logic          push, pop;

    logic signed [AW-1:0] bias_ext;
    assign bias_ext = {{(AW-32){bias[31]}}, bias};

    // A beat coincident with start is col 0 of the new strip.
    assign eff_col = start ? '0 : col_cnt_q;
    assign kept    = res_valid && (eff_col >= WARM_COLS);

    // S1 occupancy is counted so a registered beat always has a FIFO slot.
    assign occ      = count_q + {{PW{1'b0}}, s1_valid_q};
    assign in_ready = (occ < DEPTH);

    always_comb begin
        col_cnt_d    = col_cnt_q;
        strip_done_d = 1'b0;
        if (start) begin
            col_cnt_d = res_valid ? CW'(1) : '0;
        end else if (res_valid) begin
            strip_done_d = (col_cnt_q == LAST_COL);
            col_cnt_d    = (col_cnt_q == LAST_COL) ? '0 : col_cnt_q + 1'b1;
        end
    end

    always_comb begin
        overflow_d = start ? 1'b0 : overflow_q;
        if (kept && !in_ready) begin
            overflow_d = 1'b1;
        end
        s1_valid_d = kept && in_ready;
    end

    // Per-lane requantization: bias, round-half-up shift, clamp.
    generate
        for (genvar gi = 0; gi < NUM_KCELLS; gi++) begin : g_lane
            logic [OW-1:0]        lane_raw;
            logic signed [AW-1:0] lane_sum;
            logic signed [AW-1:0] lane_rnd;
            logic signed [AW-1:0] lane_shf;
            logic [DW-1:0]        lane_sat;

            assign lane_raw = result[gi*OW +: OW];
            assign lane_sum = {{(AW-OW){lane_raw[OW-1]}}, lane_raw} + bias_ext;
            assign lane_rnd = (shift != 5'd0) ? (ONE << (shift - 5'd1)) : '0;
            assign lane_shf = (lane_sum + lane_rnd) >>> shift;

            always_comb begin
                lane_sat = lane_shf[DW-1:0];
                if (relu_en) begin
                    if (lane_shf < 0) begin
                        lane_sat = '0;
                    end else if (lane_shf > U_MAX) begin
                        lane_sat = '1;
                    end
                end else begin
                    if (lane_shf > S_MAX) begin
                        lane_sat = S_MAX[DW-1:0];
                    end else if (lane_shf < S_MIN) begin
                        lane_sat = S_MIN[DW-1:0];
                    end
                end
            end

            assign s1_data_d[gi*DW +: DW] = lane_sat;
        end
    endgenerate

    assign push      = s1_valid_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt_q    <= '0;
            strip_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            strip_done_q <= strip_done_d;
            overflow_q   <= overflow_d;
            s1_valid_q   <= s1_valid_d;
            if (s1_valid_d) begin
                s1_data_q <= s1_data_d;
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset; only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    assign strip_done = strip_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dw_result_drain.sv
// Directed bench for dw_result_drain: warm-up drop, requantization, back-pressure,
// reset and start handling, each checked against hand-computed values.
module tb_dw_result_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        res_valid;
    logic [95:0] result;
    logic signed [31:0] bias;
    logic [4:0]  shift;
    logic        relu_en;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        strip_done;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sd_cnt = 0;
    int sd_cyc = -1;
    int first_valid = -1;
    logic [23:0] pop_q[$];

    always #5 clk = ~clk;

    dw_result_drain dut (
        .clk(clk), .reset(reset), .start(start), .res_valid(res_valid),
        .result(result), .bias(bias), .shift(shift), .relu_en(relu_en),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .strip_done(strip_done), .overflow(overflow)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [95:0] pack3(input int a, input int b, input int c);
        return {c, b, a};
    endfunction

    function automatic logic [23:0] pop_at(input int i);
        if (i < pop_q.size()) return pop_q[i];
        return 24'hxxxxxx;
    endfunction

    task automatic tick();
        if (out_valid && out_ready) pop_q.push_back(out_data);
        @(posedge clk);
        #1;
        cyc++;
        if (strip_done) begin
            sd_cnt++;
            sd_cyc = cyc;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
    endtask

    task automatic send(input int a, input int b, input int c);
        res_valid = 1'b1;
        result    = pack3(a, b, c);
        tick();
        res_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic start_strip();
        pulse_start();
        send(999, 999, 999);
        send(999, 999, 999);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; res_valid = 1'b0; result = '0;
        bias = 0; shift = 5'd0; relu_en = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (strip_done !== 1'b0) begin errors++; $display("FAIL reset_strip_done: got %b expected 0", strip_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        $display("test_reset done");
    endtask

    task automatic test_full_strip();
        int beat2_cyc;
        int last_cyc;
        int bad;
        int ir_low;
        bad = 0; ir_low = 0; beat2_cyc = 0; last_cyc = 0;
        bias = 8; shift = 5'd4; relu_en = 1'b1; out_ready = 1'b1;
        pulse_start();
        pop_q.delete(); sd_cnt = 0; sd_cyc = -1; first_valid = -1;
        for (int i = 0; i < 114; i++) begin
            if (!in_ready) ir_low++;
            send(100, 100, 100);
            if (i == 2) beat2_cyc = cyc;
            if (i == 113) last_cyc = cyc;
        end
        for (int i = 0; i < 6; i++) tick();
        foreach (pop_q[i]) if (pop_q[i] !== 24'h070707) bad++;
        checks++; if (pop_q.size() != 112) begin errors++; $display("FAIL strip_out_count: got %0d expected 112", pop_q.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL strip_lane_value: %0d beats differ from 070707 (first %h)", bad, pop_at(0)); end
        checks++; if (first_valid != beat2_cyc + 1) begin errors++; $display("FAIL strip_latency: first out_valid at cycle %0d expected %0d", first_valid, beat2_cyc + 1); end
        checks++; if (sd_cnt != 1) begin errors++; $display("FAIL strip_done_count: got %0d expected 1", sd_cnt); end
        checks++; if (sd_cyc != last_cyc) begin errors++; $display("FAIL strip_done_timing: got cycle %0d expected %0d", sd_cyc, last_cyc); end
        checks++; if (ir_low != 0) begin errors++; $display("FAIL strip_in_ready: low on %0d beats expected 0", ir_low); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL strip_overflow: got %b expected 0", overflow); end
        $display("test_full_strip done: %0d outputs", pop_q.size());
    endtask

    task automatic test_clamp();
        out_ready = 1'b1;
        start_strip();
        pop_q.delete();
        bias = 0; shift = 5'd0; relu_en = 1'b1;
        send(-50, 300, 100000);
        relu_en = 1'b0;
        send(-50, 300, 100000);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pop_q.size() != 2) begin errors++; $display("FAIL clamp_count: got %0d expected 2", pop_q.size()); end
        checks++; if (pop_at(0) !== 24'hFFFF00) begin errors++; $display("FAIL clamp_relu: got %h expected FFFF00", pop_at(0)); end
        checks++; if (pop_at(1) !== 24'h7F7FCE) begin errors++; $display("FAIL clamp_signed: got %h expected 7F7FCE", pop_at(1)); end
        $display("test_clamp done");
    endtask

    task automatic test_round();
        out_ready = 1'b1;
        start_strip();
        pop_q.delete();
        relu_en = 1'b0;
        bias = 0;  shift = 5'd4; send(24, -24, 0);
        bias = -8; shift = 5'd0; send(24, 7, -9);
        bias = 0;  shift = 5'd1; send(3, -3, 1);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pop_q.size() != 3) begin errors++; $display("FAIL round_count: got %0d expected 3", pop_q.size()); end
        checks++; if (pop_at(0) !== 24'h00FF02) begin errors++; $display("FAIL round_shift4: got %h expected 00FF02", pop_at(0)); end
        checks++; if (pop_at(1) !== 24'hEFFF10) begin errors++; $display("FAIL round_bias: got %h expected EFFF10", pop_at(1)); end
        checks++; if (pop_at(2) !== 24'h01FF02) begin errors++; $display("FAIL round_shift1: got %h expected 01FF02", pop_at(2)); end
        $display("test_round done");
    endtask

    task automatic test_backpressure();
        logic [23:0] exp;
        out_ready = 1'b0;
        bias = 0; shift = 5'd0; relu_en = 1'b0;
        start_strip();
        pop_q.delete();
        for (int j = 1; j <= 4; j++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_%0d: got %b expected 1", j, in_ready); end
            send(j, j + 10, j + 20);
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow_pre: got %b expected 0", overflow); end
        send(5, 15, 25);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_set: got %b expected 1", overflow); end
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 24'h150B01) begin errors++; $display("FAIL bp_hold_data: got %h expected 150B01", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (pop_q.size() != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", pop_q.size()); end
        for (int j = 1; j <= 4; j++) begin
            exp = {8'(j + 20), 8'(j + 10), 8'(j)};
            checks++; if (pop_at(j - 1) !== exp) begin errors++; $display("FAIL bp_drain_%0d: got %h expected %h", j, pop_at(j - 1), exp); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %b expected 1", in_ready); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b expected 1", overflow); end
        pulse_start();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow_clear: got %b expected 0", overflow); end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        bias = 0; shift = 5'd0; relu_en = 1'b0;
        start_strip();
        send(1, 2, 3); send(4, 5, 6); send(7, 8, 9);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_queued: got %b expected 1", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL rmid_out_data: got %h expected 000000", out_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        pop_q.delete();
        out_ready = 1'b1;
        pulse_start();
        send(70, 71, 72); send(73, 74, 75); send(40, 41, 42);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pop_q.size() != 1) begin errors++; $display("FAIL rmid_count: got %0d expected 1", pop_q.size()); end
        checks++; if (pop_at(0) !== 24'h2A2928) begin errors++; $display("FAIL rmid_data: got %h expected 2A2928", pop_at(0)); end
        $display("test_reset_mid done");
    endtask

    task automatic test_start_coincident();
        out_ready = 1'b1;
        bias = 0; shift = 5'd0; relu_en = 1'b0;
        pop_q.delete();
        start = 1'b1;
        send(90, 91, 92);
        start = 1'b0;
        send(93, 94, 95);
        send(50, 51, 52);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pop_q.size() != 1) begin errors++; $display("FAIL startco_count: got %0d expected 1", pop_q.size()); end
        checks++; if (pop_at(0) !== 24'h343332) begin errors++; $display("FAIL startco_data: got %h expected 343332", pop_at(0)); end
        $display("test_start_coincident done");
    endtask

    initial begin
        test_reset();
        test_full_strip();
        test_clamp();
        test_round();
        test_backpressure();
        test_reset_mid();
        test_start_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dw_result_drain.md
# dw_result_drain

Downstream stage of `dw_systolic`. Consumes the raw per-column partial-sum vector (`NUM_KCELLS` lanes of `OUT_DATA_WIDTH`), drops the column-window warm-up beats at the start of every activation strip, requantizes each lane to `DATA_WIDTH` (bias, rounding shift, optional ReLU, saturation), and delivers packed output columns through a ready/valid FIFO to the output-activation buffer writer. Because the array cannot stall, the block also reports back-pressure and overflow to the sequencer.

## Interface
- `DATA_WIDTH`, 8: output lane width.
- `OUT_DATA_WIDTH`, 32: input lane width; matches the `dw_systolic` result width.
- `NUM_KCELLS`, 3: lanes per beat, one per output row.
- `STRIP_COLS`, 114: result beats per strip, padded width included.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse; clears column/strip counters and `overflow`.
- `res_valid` in 1: `result` holds a column beat this cycle.
- `result` in `NUM_KCELLS*OUT_DATA_WIDTH`: signed lanes; lane k at bits [k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH].
- `bias` in 32: signed channel bias, stable while streaming.
- `shift` in 5: right-shift amount, 0..31.
- `relu_en` in 1: 1 selects unsigned [0,255] clamp; 0 selects signed [-128,127].
- `in_ready` out 1: a kept beat presented now has a reserved slot.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `NUM_KCELLS*DATA_WIDTH`: output column, lane k at [k*DATA_WIDTH +: DATA_WIDTH].
- `strip_done` out 1: one-cycle pulse when the last beat of a strip is consumed.
- `overflow` out 1: sticky; a kept beat arrived while `in_ready`=0.

## Operation
- `col_cnt` counts `res_valid` beats from 0 to STRIP_COLS-1 and then wraps to 0. `strip_done` pulses in the cycle after the beat with `col_cnt`=STRIP_COLS-1.
- Beats with `col_cnt` < NUM_KCELLS-1 are warm-up beats. They are discarded, reserve no slot, and never set `overflow`.
- A kept beat with `in_ready`=1 is registered into stage S1. A kept beat with `in_ready`=0 is dropped, `overflow` is set, and `col_cnt` still advances.
- Per-lane arithmetic in S1, 34-bit signed:
  - s = result_k + bias
  - if shift > 0, s += 1 << (shift-1) (round half up)
  - s >>>= shift (arithmetic shift)
  - clamp to the range selected by `relu_en`
- S1 writes into the FIFO on the next edge. `out_data` is the FIFO head. The FIFO pops on `out_valid && out_ready`.
- Occupancy occ = fifo_count + s1_valid. `in_ready` = (occ < FIFO_DEPTH). S1 is included in the count, so a write never finds the FIFO full.
- A pop and a write in the same cycle leave the count unchanged.
- `start` has priority over counting. A `res_valid` beat in the same cycle as `start` becomes col 0 of the new strip and is discarded as warm-up. `start` does not flush S1 or the FIFO.
- `shift`, `bias` and `relu_en` are sampled at S1 capture. Changing them mid-strip affects only later beats.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=1, `strip_done`=0, `overflow`=0, `col_cnt`=0, S1 and FIFO empty.
- Reset asserted mid-stream empties everything immediately, with no output beat emitted.
- Latency: kept beat sampled at edge N → S1 valid after N → FIFO entry and `out_valid`=1 after edge N+1, when the FIFO was empty. Lower throughput is one column per cycle with `out_ready` held high.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0. `out_valid` never drops without a pop.
- `in_ready` is a registered-state function and is combinationally independent of `res_valid`.

## Test plan
- Reset, then `start`, 114 beats with all lanes = 100, bias=8, shift=4, relu_en=1, `out_ready`=1 → exactly 112 outputs with every lane = 7. First `out_valid` appears 2 cycles after beat index 2. `strip_done` pulses once.
- Lanes = {-50, 300, 100000}, bias=0, shift=0, relu_en=1 → {0, 255, 255}. With relu_en=0 → {-50→0xCE, 127, 127}.
- Rounding: lane=24, bias=0, shift=4 → 2 (24+8=32, 32>>>4). Lane=-24 → -1 (-24+8=-16, -16>>>4).
- `out_ready`=0 during a full strip → `in_ready` falls after 4 kept beats. The 5th kept beat sets `overflow`. Raising `out_ready` drains exactly 4 entries in order.
- `reset` asserted mid-strip with 3 entries queued → `out_valid`=0 and `in_ready`=1 immediately. After release plus `start`, the warm-up beats are dropped again.
- `start` coincident with `res_valid` → that beat is discarded. The next kept output corresponds to the 3rd beat counted from `start`.
